// File: rtl/multisim_arb_pkg.sv
// Shared types and helpers for the multisim_client requester arbiter.
package multisim_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 64;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multisim_arb_rr_pick.sv
// Combinational rotating-priority search: first valid requester at or above rr_ptr, wrapping.
module multisim_arb_rr_pick
    import multisim_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vld,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] sel,
    output logic             any
);

    always_comb begin
        logic [IDX_W:0] pos;
        sel = '0;
        any = 1'b0;
        pos = '0;
        // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N_REQ)) begin
                pos = pos - (IDX_W+1)'(N_REQ);
            end
            if (req_vld[pos[IDX_W-1:0]]) begin
                sel = pos[IDX_W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multisim_client_arbiter.sv
// Round-robin arbiter sharing one multisim_client data channel among N_REQ cpu requesters.
// Define MULTISIM_ARB_OUT_REG_EN to place a one-entry register between arbitration and out_*.
module multisim_client_arbiter
    import multisim_arb_pkg::*;
#(
    parameter  int N_REQ  = N_REQ_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int IDX_W  = idx_w(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_vld,
    output logic [N_REQ-1:0]             req_rdy,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DATA_W-1:0]            out_data,
    output logic [IDX_W-1:0]             out_idx
);

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] pick_sel;
    logic             pick_any;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;
    logic             arb_rdy;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    multisim_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_vld (req_vld),
        .rr_ptr  (rr_ptr),
        .sel     (pick_sel),
        .any     (pick_any)
    );

    // A lock pins the grant so the offered payload stays stable until it is taken.
    assign arb_idx = (state == LOCKED) ? lock_idx : pick_sel;
    assign arb_vld = rst_n && ((state == LOCKED) ? req_vld[lock_idx] : pick_any);

    always_comb begin
        req_rdy = '0;
        if (arb_vld) begin
            req_rdy[arb_idx] = arb_rdy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        if (arb_rdy) begin
                            rr_ptr <= idx_inc(pick_sel);
                        end else begin
                            lock_idx <= pick_sel;
                            state    <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // A requester withdrawing while locked is dropped without advancing rr_ptr.
                    if (!req_vld[lock_idx]) begin
                        state <= IDLE;
                    end else if (arb_rdy) begin
                        rr_ptr <= idx_inc(lock_idx);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULTISIM_ARB_OUT_REG_EN
    logic              reg_vld;
    logic [DATA_W-1:0] reg_data;
    logic [IDX_W-1:0]  reg_idx;

    assign arb_rdy = !reg_vld || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_vld  <= 1'b0;
            reg_data <= '0;
            reg_idx  <= '0;
        end else if (arb_vld && arb_rdy) begin
            reg_vld  <= 1'b1;
            reg_data <= req_data[arb_idx];
            reg_idx  <= arb_idx;
        end else if (out_rdy) begin
            reg_vld  <= 1'b0;
        end
    end

    assign out_vld  = reg_vld;
    assign out_data = reg_data;
    assign out_idx  = reg_idx;
`else
    assign arb_rdy  = out_rdy;
    assign out_vld  = arb_vld;
    assign out_data = arb_vld ? req_data[arb_idx] : '0;
    assign out_idx  = arb_vld ? arb_idx : '0;
`endif

endmodule

// File: tb/tb_multisim_client_arbiter.sv
// Bench for multisim_client_arbiter: directed grant/lock/reset cases plus a random scoreboard run.
module tb_multisim_client_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int NX = 1000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_vld;
    logic [N-1:0]         req_rdy;
    logic [N-1:0][DW-1:0] req_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic [DW-1:0]        out_data;
    logic [1:0]           out_idx;

    logic       s_vld, s_rdy, s_out_vld, s_out_rdy, s_out_idx;
    logic [7:0] s_data, s_out_data;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] exp_q [N][$];
    int          issued [N];
    int          done_cnt [N];

    always #5 clk = ~clk;

    multisim_client_arbiter #(.N_REQ(N), .DATA_W(DW)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_data (req_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_idx  (out_idx)
    );

    multisim_client_arbiter #(.N_REQ(1), .DATA_W(8)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (s_vld),
        .req_rdy  (s_rdy),
        .req_data (s_data),
        .out_vld  (s_out_vld),
        .out_rdy  (s_out_rdy),
        .out_data (s_out_data),
        .out_idx  (s_out_idx)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_vld = '0;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] hs;
        logic [63:0]  e;
        int           cyc_n;
        bit           all_done;

        rst_n     = 1'b0;
        s_vld     = 1'b0;
        s_out_rdy = 1'b0;
        s_data    = '0;
        for (int i = 0; i < N; i++) req_data[i] = 64'hA000 + 64'(i);

        // Reset state with every requester asking
        req_vld = '1;
        out_rdy = 1'b1;
        #2;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

`ifndef MULTISIM_ARB_OUT_REG_EN
        // All requesting, out_rdy high: 0,1,2,3,0 one per cycle
        for (int k = 0; k < 5; k++) begin
            chk("rr_vld", out_vld, 1);
            chk("rr_idx", out_idx, k % 4);
            chk("rr_rdy", req_rdy, 1 << (k % 4));
            chk("rr_data", out_data, 64'hA000 + 64'(k % 4));
            @(posedge clk);
            #1;
        end

        // Backpressure: hold index 0 for 3 stalled cycles, take it, then grant 2
        do_reset();
        req_vld = 4'b0101;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("lock_vld", out_vld, 1);
            chk("lock_idx", out_idx, 0);
            chk("lock_data", out_data, 64'hA000);
            chk("lock_rdy", req_rdy, 0);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        #1;
        chk("lock_take_idx", out_idx, 0);
        chk("lock_take_rdy", req_rdy, 4'b0001);
        @(posedge clk);
        #1;
        chk("lock_next_idx", out_idx, 2);
        chk("lock_next_data", out_data, 64'hA002);

        // Wrap search: rr_ptr=3 with only requester 1, then rr_ptr must be 2
        do_reset();
        req_vld = 4'b0100;
        out_rdy = 1'b1;
        #1;
        chk("wrap_pre_idx", out_idx, 2);
        @(posedge clk);
        #1;
        req_vld = 4'b0010;
        #1;
        chk("wrap_idx", out_idx, 1);
        chk("wrap_rdy", req_rdy, 4'b0010);
        @(posedge clk);
        #1;
        req_vld = 4'b1010;
        #1;
        chk("wrap_ptr_idx", out_idx, 3);

        // Locked requester withdraws: no transfer, rr_ptr stays 0
        do_reset();
        req_vld = 4'b0010;
        #1;
        chk("drop_pre_idx", out_idx, 1);
        @(posedge clk);
        #1;
        req_vld = 4'b0000;
        #1;
        chk("drop_vld", out_vld, 0);
        chk("drop_rdy", req_rdy, 0);
        @(posedge clk);
        #1;
        req_vld = 4'b1111;
        out_rdy = 1'b1;
        #1;
        chk("drop_after_idx", out_idx, 0);

        // Reset while locked on 2 abandons it; grants restart at 0
        do_reset();
        req_vld = 4'b0100;
        #1;
        @(posedge clk);
        #1;
        req_vld = 4'b1111;
        #1;
        chk("rstlk_hold_idx", out_idx, 2);
        chk("rstlk_hold_rdy", req_rdy, 0);
        rst_n = 1'b0;
        #1;
        chk("rstlk_vld", out_vld, 0);
        chk("rstlk_rdy", req_rdy, 0);
        chk("rstlk_idx", out_idx, 0);
        chk("rstlk_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        #1;
        chk("rstlk_first_idx", out_idx, 0);
        chk("rstlk_first_rdy", req_rdy, 4'b0001);
        @(posedge clk);
        #1;
        chk("rstlk_second_idx", out_idx, 1);

        // Single requester pass-through
        s_vld  = 1'b1;
        s_data = 8'h5A;
        #1;
        chk("one_vld", s_out_vld, 1);
        chk("one_rdy_lo", s_rdy, 0);
        chk("one_data", s_out_data, 8'h5A);
        chk("one_idx", s_out_idx, 0);
        s_out_rdy = 1'b1;
        #1;
        chk("one_rdy_hi", s_rdy, 1);
        s_vld = 1'b0;
        #1;
        chk("one_idle", s_out_vld, 0);
`else
        // Registered output: data appears one cycle after the requester handshake
        do_reset();
        req_data[0] = 64'hDEAD_BEEF;
        req_vld     = 4'b0001;
        out_rdy     = 1'b1;
        #1;
        chk("oreg_req_rdy", req_rdy, 4'b0001);
        chk("oreg_pre_vld", out_vld, 0);
        @(posedge clk);
        #1;
        req_vld = '0;
        #1;
        chk("oreg_vld", out_vld, 1);
        chk("oreg_data", out_data, 64'hDEAD_BEEF);
        chk("oreg_idx", out_idx, 0);
        @(posedge clk);
        #1;
        chk("oreg_drain", out_vld, 0);
`endif

        // Random vld/rdy with per-requester ordered scoreboard
        do_reset();
        for (int r = 0; r < N; r++) begin
            issued[r]   = 0;
            done_cnt[r] = 0;
        end
        cyc_n    = 0;
        all_done = 1'b0;
        while (!all_done && cyc_n < 40000) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < N; r++) begin
                if (!req_vld[r] && issued[r] < NX && $urandom_range(0, 1) == 1) begin
                    req_data[r] = (64'(r) << 32) | 64'(issued[r]);
                    req_vld[r]  = 1'b1;
                    exp_q[r].push_back(req_data[r]);
                    issued[r]++;
                end
            end
            #3;
            chk("rdy_onehot", req_rdy & (req_rdy - 4'd1), 0);
            hs = req_vld & req_rdy;
            if (out_vld && out_rdy) begin
                if (exp_q[out_idx].size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    e = exp_q[out_idx].pop_front();
                    chk("sb_data", out_data, e);
                    done_cnt[out_idx]++;
                end
            end
            @(posedge clk);
            #1;
            cyc_n++;
            for (int r = 0; r < N; r++) begin
                if (hs[r]) req_vld[r] = 1'b0;
            end
            all_done = 1'b1;
            for (int r = 0; r < N; r++) begin
                if (done_cnt[r] < NX || exp_q[r].size() != 0) all_done = 1'b0;
            end
        end
        chk("sb_complete", all_done, 1);
        for (int r = 0; r < N; r++) chk("sb_count", done_cnt[r], NX);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multisim_client_arbiter.md
MULTISIM_CLIENT_ARBITER -- requirements
Module: multisim_client_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of cpu requesters sharing one multisim_client channel; legal range 1..16.
REQ-002 Parameter DATA_W, default 64: payload width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_vld  input  N_REQ  per-requester data valid.
REQ-006 req_rdy  output  N_REQ  per-requester data ready; at most one bit high per cycle.
REQ-007 req_data  input  N_REQ x DATA_W  per-requester payload.
REQ-008 out_vld  output  1  valid towards multisim_client data_vld.
REQ-009 out_rdy  input  1  ready from multisim_client data_rdy.
REQ-010 out_data  output  DATA_W  payload towards multisim_client data.
REQ-011 out_idx  output  max(1,$clog2(N_REQ))  index of the requester owning out_data.

Function
REQ-012 A transfer SHALL occur on a requester/output pair in every cycle where vld and rdy are both high at posedge clk.
REQ-013 State machine SHALL have states IDLE and LOCKED.
REQ-014 IDLE: select the first index with req_vld high, searching from rr_ptr upward with wrap N_REQ-1 -> 0; drive out_vld=1, out_data=req_data[sel], out_idx=sel in the same cycle (zero latency).
REQ-015 IDLE with no req_vld high: out_vld=0, req_rdy=0, no state change.
REQ-016 req_rdy[sel] SHALL equal out_rdy; all other req_rdy bits SHALL be 0.
REQ-017 IDLE, selection made and out_rdy=1: transfer, rr_ptr <= (sel+1) mod N_REQ, stay IDLE (back-to-back transfers at 1 per cycle).
REQ-018 IDLE, selection made and out_rdy=0: latch sel into lock_idx, go LOCKED.
REQ-019 LOCKED: grant held on lock_idx regardless of other req_vld; out_data/out_idx from lock_idx, keeping out_* stable until transfer.
REQ-020 LOCKED with out_rdy=1: transfer, rr_ptr <= (lock_idx+1) mod N_REQ, go IDLE.
REQ-021 LOCKED with req_vld[lock_idx]=0 (protocol violation): out_vld=0, go IDLE, rr_ptr unchanged, no transfer.
REQ-022 rr_ptr SHALL advance only on a transfer; starvation bound is N_REQ-1 transfers of other requesters.
REQ-023 N_REQ=1: behaves as a pass-through with out_idx=0.

Reset
REQ-024 While rst_n=0: state=IDLE, rr_ptr=0, lock_idx=0, out_vld=0, req_rdy=0, out_data=0, out_idx=0.
REQ-025 Reset asserted while LOCKED SHALL abandon the pending payload; no transfer is counted and first grant after reset starts from index 0.

Configuration
REQ-026 Macro MULTISIM_ARB_OUT_REG_EN defined: a one-entry output register sits between arbitration and out_*; out_vld/out_data/out_idx are flop outputs; arbiter-side transfer occurs when register is empty or drains in the same cycle; latency 1 cycle, throughput 1 per cycle with out_rdy held high; register cleared by reset.
REQ-027 Macro undefined: out_* combinational from the selected requester per REQ-014..REQ-021, zero latency.

Structure
REQ-028 Package multisim_arb_pkg SHALL hold typedef arb_state_e {IDLE, LOCKED}, default N_REQ/DATA_W constants, and the index-width function.
REQ-029 Sub-module multisim_arb_rr_pick SHALL implement the combinational rotating-priority search (inputs req_vld, rr_ptr; outputs sel, any).

Verification
REQ-030 req_vld=4'b1111, out_rdy=1 constant from reset -> out_idx sequence 0,1,2,3,0 on consecutive cycles, one transfer per cycle.
REQ-031 req_vld=4'b0101, out_rdy=0 for 3 cycles then 1 -> out_idx=0 held stable with data 4 cycles, then next grant out_idx=2.
REQ-032 rr_ptr=3 with only req_vld[1]=1 -> wrap search grants index 1, next rr_ptr=2.
REQ-033 rst_n pulsed low while LOCKED on index 2 -> all outputs 0 immediately, after release first grant from index 0 with no duplicate transfer.
REQ-034 MULTISIM_ARB_OUT_REG_EN defined, single request data=64'hDEAD_BEEF, out_rdy=1 -> out_vld rises exactly 1 cycle after req_rdy handshake with out_data=64'hDEAD_BEEF.
REQ-035 Random vld/rdy on 4 cpu instances, 1000 transfers each -> per-requester payload order preserved, no loss/duplication, req_rdy one-hot-or-zero every cycle.
